// File: rtl/gpu_cmd_arbiter_if.sv
// Bundle of both command sources and the GPU instruction write port.
// The arbiter uses the slave view; whoever drives the sources and models the GPU uses the master view.
interface gpu_cmd_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             s0_valid;
    logic [31:0]      s0_data_a;
    logic [31:0]      s0_data_b;
    logic             s0_ready;
    logic             s1_valid;
    logic [31:0]      s1_data_a;
    logic [31:0]      s1_data_b;
    logic             s1_sync;
    logic             s1_ready;
    logic             wrfull;
    logic             screen;
    logic [31:0]      data_a;
    logic [31:0]      data_b;
    logic             wrreg;
    logic             busy;
    logic [CNT_W-1:0] issued_count;

    modport slave (
        input  s0_valid, s0_data_a, s0_data_b,
        input  s1_valid, s1_data_a, s1_data_b, s1_sync,
        input  wrfull, screen,
        output s0_ready, s1_ready,
        output data_a, data_b, wrreg, busy, issued_count
    );

    modport master (
        output s0_valid, s0_data_a, s0_data_b,
        output s1_valid, s1_data_a, s1_data_b, s1_sync,
        output wrfull, screen,
        input  s0_ready, s1_ready,
        input  data_a, data_b, wrreg, busy, issued_count
    );
endinterface

// File: rtl/gpu_cmd_arbiter.sv
// Round-robin arbiter sharing the GPU instruction write port between software (s0) and the game engine (s1).
// Every write is sequenced as setup -> one-cycle wrreg strobe -> gap; s1 may be held for a frame boundary.
module gpu_cmd_arbiter #(
    parameter int SETUP_CYCLES = 1,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    gpu_cmd_arbiter_if.slave   bus
);
    localparam int CW = $clog2(SETUP_CYCLES + GAP_CYCLES + 1) + 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      data_a_q, data_a_d;
    logic [31:0]      data_b_q, data_b_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_grant_q, last_grant_d;
    logic             frame_flag_q, frame_flag_d;
    logic             screen_q, screen_d;

    logic e0, e1, grant0, grant1, ready0, ready1, frame_rise;

    always_comb begin
        e0     = bus.s0_valid;
        e1     = bus.s1_valid & (~bus.s1_sync | frame_flag_q);
        // On a tie the source that did not win last time gets the port.
        grant0 = e0 & (~e1 | last_grant_q);
        grant1 = e1 & (~e0 | ~last_grant_q);
        ready0 = (state_q == IDLE) & ~bus.wrfull & grant0;
        ready1 = (state_q == IDLE) & ~bus.wrfull & grant1;
        frame_rise = bus.screen & ~screen_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        screen_d     = bus.screen;
        frame_flag_d = frame_flag_q;

        // A new frame edge wins over a simultaneous consume by a sync command.
        if (frame_rise) begin
            frame_flag_d = 1'b1;
        end else if (ready1 & bus.s1_sync) begin
            frame_flag_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ready0) begin
                    data_a_d     = bus.s0_data_a;
                    data_b_d     = bus.s0_data_b;
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = SETUP;
                end else if (ready1) begin
                    data_a_d     = bus.s1_data_a;
                    data_b_d     = bus.s1_data_b;
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (!bus.wrfull) begin
                    if (cnt_q == SETUP_LAST) begin
                        state_d = STROBE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            STROBE: begin
                count_d = count_q + CNT_W'(1);
                cnt_d   = '0;
                state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            frame_flag_q <= 1'b0;
            screen_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            frame_flag_q <= frame_flag_d;
            screen_q     <= screen_d;
        end
    end

    assign bus.s0_ready     = ready0;
    assign bus.s1_ready     = ready1;
    assign bus.data_a       = data_a_q;
    assign bus.data_b       = data_b_q;
    assign bus.wrreg        = (state_q == STROBE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.issued_count = count_q;
endmodule

// File: tb/tb_gpu_cmd_arbiter.sv
// Directed bench for gpu_cmd_arbiter: handshake, round-robin, FIFO-full stalls, frame sync, reset abort, counter wrap.
// A narrow issued_count keeps the wrap test short.
module tb_gpu_cmd_arbiter;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [31:0] strobe_a[$];
    logic [31:0] strobe_b[$];
    int          strobe_cyc[$];

    gpu_cmd_arbiter_if #(.CNT_W(CNT_W)) bus ();

    gpu_cmd_arbiter #(
        .SETUP_CYCLES(1),
        .GAP_CYCLES  (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One line per issued GPU write.
    always @(negedge clk) begin
        if (bus.wrreg) begin
            strobe_a.push_back(bus.data_a);
            strobe_b.push_back(bus.data_b);
            strobe_cyc.push_back(cyc);
            $display("strobe cyc=%0d a=%08h b=%08h count=%0d", cyc, bus.data_a, bus.data_b, bus.issued_count);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 30 && bus.busy; k++) step();
        check("idle_timeout", bus.busy, 0);
    endtask

    initial begin
        int grants[$];
        int conflicts;
        int i0, i1;
        logic seen, got;
        logic [31:0] exp_a[4];

        bus.s0_valid = 0; bus.s0_data_a = 0; bus.s0_data_b = 0;
        bus.s1_valid = 0; bus.s1_data_a = 0; bus.s1_data_b = 0; bus.s1_sync = 0;
        bus.wrfull = 0; bus.screen = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_a", bus.data_a, 0);
        check("rst_data_b", bus.data_b, 0);
        check("rst_wrreg", bus.wrreg, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.issued_count, 0);
        rst_n = 1;
        step();

        // 1: single s0 command
        bus.s0_valid = 1; bus.s0_data_a = 32'h11; bus.s0_data_b = 32'hABCD;
        #1;
        check("t1_ready", bus.s0_ready, 1);
        step();
        bus.s0_valid = 0;
        #1;
        check("t1_ready_pulse", bus.s0_ready, 0);
        check("t1_data_a", bus.data_a, 32'h11);
        check("t1_data_b", bus.data_b, 32'hABCD);
        check("t1_setup_wrreg", bus.wrreg, 0);
        check("t1_busy_setup", bus.busy, 1);
        step();
        check("t1_wrreg", bus.wrreg, 1);
        step();
        check("t1_wrreg_once", bus.wrreg, 0);
        check("t1_count", bus.issued_count, 1);
        check("t1_busy_gap", bus.busy, 1);
        step();
        check("t1_busy_gap2", bus.busy, 1);
        step();
        check("t1_busy_end", bus.busy, 0);

        // 2: both sources valid; s0 won last, so s1 is granted first
        strobe_a.delete(); strobe_b.delete(); strobe_cyc.delete();
        i0 = 0; i1 = 0; conflicts = 0;
        bus.s0_valid = 1; bus.s0_data_a = 32'hA000_0000; bus.s0_data_b = 32'hB000_0000;
        bus.s1_valid = 1; bus.s1_data_a = 32'hC100_0000; bus.s1_data_b = 32'hD100_0000; bus.s1_sync = 0;
        #1;
        for (int k = 0; k < 60 && strobe_a.size() < 4; k++) begin
            logic r0, r1;
            r0 = bus.s0_ready; r1 = bus.s1_ready;
            if (r0 && r1) conflicts++;
            if (r0) grants.push_back(0);
            if (r1) grants.push_back(1);
            step();
            if (r0) begin i0++; bus.s0_data_a = 32'hA000_0000 + i0; bus.s0_data_b = 32'hB000_0000 + i0; end
            if (r1) begin i1++; bus.s1_data_a = 32'hC100_0000 + i1; bus.s1_data_b = 32'hD100_0000 + i1; end
            if (grants.size() >= 4) begin bus.s0_valid = 0; bus.s1_valid = 0; end
        end
        wait_idle();
        check("t2_one_ready", conflicts, 0);
        check("t2_n_grants", grants.size(), 4);
        check("t2_n_strobes", strobe_a.size(), 4);
        exp_a[0] = 32'hC100_0000; exp_a[1] = 32'hA000_0000;
        exp_a[2] = 32'hC100_0001; exp_a[3] = 32'hA000_0001;
        if (grants.size() >= 4 && strobe_a.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t2_grant%0d", k), grants[k], (k % 2 == 0) ? 1 : 0);
                check($sformatf("t2_payload%0d", k), strobe_a[k], exp_a[k]);
            end
            check("t2_payload_b3", strobe_b[3], 32'hB000_0001);
            for (int k = 1; k < 4; k++)
                check($sformatf("t2_spacing%0d", k), strobe_cyc[k] - strobe_cyc[k-1], 5);
        end

        // 3: FIFO full blocks acceptance, then stalls SETUP
        bus.wrfull = 1;
        bus.s0_valid = 1; bus.s0_data_a = 32'h33; bus.s0_data_b = 32'h3333;
        #1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            seen |= bus.s0_ready | bus.s1_ready | bus.wrreg;
            step();
        end
        check("t3_full_block", seen, 0);
        bus.wrfull = 0;
        #1;
        check("t3_accept", bus.s0_ready, 1);
        step();
        bus.s0_valid = 0;
        bus.wrfull = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_stall_wrreg", bus.wrreg, 0);
            check("t3_stall_data", bus.data_a, 32'h33);
        end
        bus.wrfull = 0;
        step();
        check("t3_late_strobe", bus.wrreg, 1);
        check("t3_data_b", bus.data_b, 32'h3333);
        wait_idle();

        // 4: sync commands wait for a screen rising edge
        bus.s1_valid = 1; bus.s1_sync = 1; bus.s1_data_a = 32'h4000_0001; bus.s1_data_b = 32'h4;
        bus.screen = 0;
        #1;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            seen |= bus.s1_ready | bus.s0_ready;
            step();
        end
        check("t4_sync_hold", seen, 0);
        bus.screen = 1;
        got = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (bus.s1_ready) begin got = 1; break; end
        end
        check("t4_sync_grant", got, 1);
        if (got) step();
        bus.s1_data_a = 32'h4000_0002;
        #1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            seen |= bus.s1_ready;
            step();
        end
        check("t4_no_retrigger", seen, 0);
        bus.screen = 0;
        step();
        bus.screen = 1;
        got = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (bus.s1_ready) begin got = 1; break; end
        end
        check("t4_sync_grant2", got, 1);
        if (got) step();
        bus.s1_valid = 0; bus.s1_sync = 0;
        wait_idle();
        check("t4_last_payload", strobe_a[$], 32'h4000_0002);

        // 5: reset during STROBE aborts the write
        bus.s0_valid = 1; bus.s0_data_a = 32'h55; bus.s0_data_b = 32'h5555;
        #1;
        check("t5_ready", bus.s0_ready, 1);
        step();
        bus.s0_valid = 0;
        step();
        check("t5_strobe", bus.wrreg, 1);
        rst_n = 0;
        #1;
        check("t5_abort_wrreg", bus.wrreg, 0);
        check("t5_abort_busy", bus.busy, 0);
        check("t5_abort_data", bus.data_a, 0);
        check("t5_abort_count", bus.issued_count, 0);
        step();
        step();
        rst_n = 1;
        bus.s0_valid = 1; bus.s0_data_a = 32'h66;
        bus.s1_valid = 1; bus.s1_data_a = 32'h77; bus.s1_sync = 0;
        #1;
        check("t5_first_tie_s0", bus.s0_ready, 1);
        check("t5_first_tie_s1", bus.s1_ready, 0);
        step();
        bus.s0_valid = 0; bus.s1_valid = 0;
        wait_idle();
        check("t5_count", bus.issued_count, 1);

        // 6: issued_count wraps modulo 2^CNT_W
        bus.s0_valid = 1; bus.s0_data_a = 32'h99;
        for (int k = 0; k < 2000 && bus.issued_count != 8'hFF; k++) step();
        bus.s0_valid = 0;
        check("t6_pre_wrap", bus.issued_count, 8'hFF);
        wait_idle();
        bus.s0_valid = 1;
        #1;
        check("t6_ready", bus.s0_ready, 1);
        step();
        bus.s0_valid = 0;
        wait_idle();
        check("t6_wrap", bus.issued_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
